// File: rtl/audio_frame_buffer.sv
// audio_frame_buffer
// Circular PCM sample store feeding the Hamming windower. Incoming samples are
// appended continuously; once FRAME_SIZE samples are held past frame_base a
// frame_ready_o pulse starts the windower, which then pulls the frame out
// oldest-first through the rd_en_i / valid_to_read_o handshake (1-cycle read
// latency). After the last read the frame start advances by HOP_SIZE, giving
// overlapping frames.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   sample_i          signed PCM sample, written when sample_valid_i is high
//   frame_ready_o     1-cycle pulse: a full frame is available (windower start)
//   rd_en_i           windower read request
//   valid_to_read_o   frame_sample_o carries a frame sample this cycle
//   frame_sample_o    frame sample, held when not valid
//   frame_done_i      windower finished the current frame
//   overflow_o        sticky: a sample was dropped because storage was full
//   busy_o            high from frame_ready_o until frame_done_i
module audio_frame_buffer #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int FRAME_SIZE   = 306,
  parameter int HOP_SIZE     = 122,
  parameter int BUFFER_DEPTH = 512,
  parameter int ADDR_WIDTH   = $clog2(BUFFER_DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_i,
  input  logic                           sample_valid_i,
  output logic                           frame_ready_o,
  input  logic                           rd_en_i,
  output logic                           valid_to_read_o,
  output logic signed [SAMPLE_WIDTH-1:0] frame_sample_o,
  input  logic                           frame_done_i,
  output logic                           overflow_o,
  output logic                           busy_o
);

  // occupancy must be able to hold BUFFER_DEPTH itself, hence one extra bit
  localparam int OCC_W = ADDR_WIDTH + 1;
  localparam int CNT_W = $clog2(FRAME_SIZE + 1);

  typedef enum logic [1:0] {FILL, SERVE, WAIT_DONE} state_t;

  logic signed [SAMPLE_WIDTH-1:0] mem [BUFFER_DEPTH];

  state_t              state, state_next;
  logic [ADDR_WIDTH-1:0] wr_ptr, frame_base, rd_addr;
  logic [CNT_W-1:0]      rd_count;
  logic [OCC_W-1:0]      occupancy;

  logic wr_accept, start_frame, rd_issue, last_read, frame_end;

  // Storage is full when occupancy hits the depth; later samples are dropped.
  assign wr_accept = sample_valid_i && (occupancy < OCC_W'(BUFFER_DEPTH));
  // Power-of-two depth: the address add wraps naturally.
  assign rd_addr   = frame_base + ADDR_WIDTH'(rd_count);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) state <= FILL;
    else        state <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state;
    case (state)
      FILL:      if (start_frame) state_next = SERVE;
      SERVE:     if (last_read)   state_next = WAIT_DONE;
      WAIT_DONE: if (frame_end)   state_next = FILL;
      default:                    state_next = FILL;
    endcase
  end

  // ---------------- FSM: control outputs ----------------
  always_comb begin
    start_frame = (state == FILL) && (occupancy >= OCC_W'(FRAME_SIZE));
    rd_issue    = (state == SERVE) && rd_en_i && (rd_count < CNT_W'(FRAME_SIZE));
    last_read   = rd_issue && (rd_count == CNT_W'(FRAME_SIZE - 1));
    frame_end   = (state == WAIT_DONE) && frame_done_i;
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr          <= '0;
      frame_base      <= '0;
      rd_count        <= '0;
      occupancy       <= '0;
      frame_ready_o   <= 1'b0;
      valid_to_read_o <= 1'b0;
      frame_sample_o  <= '0;
      overflow_o      <= 1'b0;
      busy_o          <= 1'b0;
    end else begin
      frame_ready_o   <= start_frame;
      valid_to_read_o <= rd_issue;

      if (start_frame) begin
        busy_o   <= 1'b1;
        rd_count <= '0;
      end else if (frame_end) begin
        busy_o   <= 1'b0;
      end

      if (rd_issue) begin
        rd_count       <= rd_count + 1'b1;
        frame_sample_o <= mem[rd_addr];
      end

      if (wr_accept)                     wr_ptr     <= wr_ptr + 1'b1;
      if (sample_valid_i && !wr_accept)  overflow_o <= 1'b1;
      if (last_read)                     frame_base <= frame_base + ADDR_WIDTH'(HOP_SIZE);

      // Write and frame advance may land in the same cycle.
      occupancy <= occupancy + OCC_W'(wr_accept)
                 - (last_read ? OCC_W'(HOP_SIZE) : OCC_W'(0));
    end
  end

  // Sample storage is deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (rst_n && wr_accept) mem[wr_ptr] <= sample_i;
  end

endmodule

// File: tb/tb_audio_frame_buffer.sv
module tb_audio_frame_buffer;
  localparam int SW    = 16;
  localparam int FRAME = 306;
  localparam int HOP   = 122;
  localparam int DEPTH = 512;

  logic clk = 1'b0;
  logic rst_n;
  logic signed [SW-1:0] sample_i;
  logic sample_valid_i, rd_en_i, frame_done_i;
  logic frame_ready_o, valid_to_read_o, overflow_o, busy_o;
  logic signed [SW-1:0] frame_sample_o;

  audio_frame_buffer #(.SAMPLE_WIDTH(SW), .FRAME_SIZE(FRAME), .HOP_SIZE(HOP),
                       .BUFFER_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .sample_i(sample_i), .sample_valid_i(sample_valid_i),
    .frame_ready_o(frame_ready_o), .rd_en_i(rd_en_i), .valid_to_read_o(valid_to_read_o),
    .frame_sample_o(frame_sample_o), .frame_done_i(frame_done_i),
    .overflow_o(overflow_o), .busy_o(busy_o));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Every accepted sample since reset is kept by absolute stream index; a
  // frame is simply hist[base .. base+FRAME-1] and base moves by HOP per frame.
  logic signed [SW-1:0] hist[$];
  logic signed [SW-1:0] exp_q[$];
  int m_base, m_phase, m_issued;   // phase: 0 waiting for data, 1 serving, 2 awaiting done
  bit m_rdy, m_vld, m_busy, m_ovf, m_rst;

  always @(posedge clk) begin
    int held;
    bit acc;
    if (!rst_n) begin
      hist.delete(); exp_q.delete();
      m_base = 0; m_phase = 0; m_issued = 0;
      m_rdy = 0; m_vld = 0; m_busy = 0; m_ovf = 0; m_rst = 1;
    end else begin
      m_rst = 0;
      held  = hist.size() - m_base;
      acc   = sample_valid_i && (held < DEPTH);
      if (sample_valid_i && !acc) m_ovf = 1;
      m_rdy = 0; m_vld = 0;
      case (m_phase)
        0: if (held >= FRAME) begin
             m_rdy = 1; m_busy = 1; m_issued = 0; m_phase = 1;
           end
        1: if (rd_en_i) begin
             exp_q.push_back(hist[m_base + m_issued]);
             m_vld = 1;
             m_issued++;
             if (m_issued == FRAME) begin m_base += HOP; m_phase = 2; end
           end
        default: if (frame_done_i) begin m_busy = 0; m_phase = 0; end
      endcase
      if (acc) hist.push_back(sample_i);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic signed [SW-1:0] mon_last = '0;

  always @(negedge clk) begin
    if (chk_en) begin
      if (m_rst) mon_last = '0;
      chk("frame_ready", {31'b0, frame_ready_o}, {31'b0, m_rdy});
      chk("busy",        {31'b0, busy_o},        {31'b0, m_busy});
      chk("overflow",    {31'b0, overflow_o},    {31'b0, m_ovf});
      chk("valid",       {31'b0, valid_to_read_o}, {31'b0, m_vld});
      if (valid_to_read_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("valid_without_expected", 32'd1, 32'd0);
        end else begin
          mon_last = exp_q.pop_front();
          chk("sample", 32'(frame_sample_o), 32'(mon_last));
        end
      end else begin
        chk("sample_hold", 32'(frame_sample_o), 32'(mon_last));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit sv, input logic [SW-1:0] val, input bit rd, input bit dn);
    sample_valid_i = sv; sample_i = val; rd_en_i = rd; frame_done_i = dn;
    @(posedge clk); #1;
  endtask

  initial begin
    bit hit;
    rst_n = 0; sample_valid_i = 0; sample_i = '0; rd_en_i = 0; frame_done_i = 0;
    repeat (3) @(posedge clk);
    #1 chk_en = 1;
    @(negedge clk);
    chk("rst_valid",  {31'b0, valid_to_read_o}, 32'd0);
    chk("rst_sample", 32'(frame_sample_o), 32'd0);
    chk("rst_busy",   {31'b0, busy_o}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1;

    // Index-valued stream with reads held high: frames 0..305, 122..427, ...
    for (int i = 0; i < 428; i++) cyc(1, SW'(i), 1, $urandom_range(0, 15) == 0);
    // Alternating read requests, random data and done pulses; crosses the wrap.
    for (int i = 0; i < 900; i++)
      cyc($urandom_range(0, 9) < 8, SW'($urandom), i[0] == 0, $urandom_range(0, 9) == 0);
    // Windower stalls: storage fills and samples get dropped.
    for (int i = 0; i < 700; i++) cyc(1, SW'($urandom), 0, 0);
    @(negedge clk);
    chk("overflow_set", {31'b0, overflow_o}, 32'd1);
    @(posedge clk); #1;
    // Service resumes; overflow must stay sticky.
    for (int i = 0; i < 700; i++)
      cyc($urandom_range(0, 1) == 1, SW'($urandom), 1, $urandom_range(0, 7) == 0);

    // Reset in the middle of serving a frame (100 reads issued).
    rst_n = 0; cyc(0, '0, 0, 0); rst_n = 1;
    hit = 0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      cyc(1, SW'($urandom), 1, 0);
      if (m_phase == 1 && m_issued == 100) hit = 1;
    end
    if (!hit) chk("reach_rd_count_100_timeout", 32'd1, 32'd0);
    rst_n = 0;
    cyc(1, SW'($urandom), 1, 0);
    @(negedge clk);
    chk("midframe_rst_valid", {31'b0, valid_to_read_o}, 32'd0);
    chk("midframe_rst_busy",  {31'b0, busy_o}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 3) != 0, SW'($urandom), $urandom_range(0, 3) != 0,
          $urandom_range(0, 5) == 0);

    // Drain whatever frame is in flight.
    for (int i = 0; i < 400; i++) cyc(0, '0, 1, 1);
    @(negedge clk); #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
